// File: rtl/gemm_op.sv
// GEMM tile core: o[i] = (acc_clear ? 0 : a[i]) + sum_j inp[j]*W[i][j], signed, modulo 2^ACC_WIDTH.
// One registered stage (1-cycle latency); no backpressure, so the consumer must take every out_valid.
module gemm_op #(
    parameter int INP_WIDTH = 8,
    parameter int WGT_WIDTH = 8,
    parameter int ACC_WIDTH = 32,
    parameter int INP_DEPTH = 16,
    parameter int WGT_DEPTH = INP_DEPTH * INP_DEPTH,
    parameter int IT_WIDTH  = INP_WIDTH * INP_DEPTH,
    parameter int WT_WIDTH  = WGT_WIDTH * WGT_DEPTH,
    parameter int AT_WIDTH  = ACC_WIDTH * INP_DEPTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic                acc_clear,
    input  logic [IT_WIDTH-1:0] i_tensor,
    input  logic [WT_WIDTH-1:0] w_tensor,
    input  logic [AT_WIDTH-1:0] a_tensor,
    output logic [AT_WIDTH-1:0] o_tensor,
    output logic                out_valid
);

    localparam int PROD_WIDTH = INP_WIDTH + WGT_WIDTH;
    localparam int TREE_LVL   = $clog2(INP_DEPTH);
    localparam int LEAVES     = 1 << TREE_LVL;
    localparam int ROW_WIDTH  = INP_DEPTH * WGT_WIDTH;

    // Dot product of one weight row with the input vector. Leaves are padded
    // to a power of two with zeros and reduced pairwise in place, so each
    // pass halves the live node count and the grouping forms a balanced tree.
    function automatic logic [ACC_WIDTH-1:0] f_dot(
        input logic [IT_WIDTH-1:0]  x,
        input logic [ROW_WIDTH-1:0] wrow
    );
        logic signed [INP_WIDTH-1:0]  xs;
        logic signed [WGT_WIDTH-1:0]  ws;
        logic signed [PROD_WIDTH-1:0] p;
        logic        [ACC_WIDTH-1:0]  node [LEAVES];
        for (int j = 0; j < LEAVES; j++) begin
            node[j] = '0;
        end
        for (int j = 0; j < INP_DEPTH; j++) begin
            xs      = x[j*INP_WIDTH +: INP_WIDTH];
            ws      = wrow[j*WGT_WIDTH +: WGT_WIDTH];
            p       = PROD_WIDTH'(xs) * PROD_WIDTH'(ws);
            node[j] = ACC_WIDTH'(p);
        end
        for (int s = LEAVES / 2; s > 0; s = s / 2) begin
            for (int k = 0; k < s; k++) begin
                node[k] = node[2*k] + node[2*k+1];
            end
        end
        return node[0];
    endfunction

    logic [AT_WIDTH-1:0]  w_sum;
    logic [ACC_WIDTH-1:0] w_acc;
    logic [AT_WIDTH-1:0]  r_out;
    logic                 r_vld;

    always_comb begin
        w_sum = '0;
        w_acc = '0;
        for (int i = 0; i < INP_DEPTH; i++) begin
            w_acc = acc_clear ? '0 : a_tensor[i*ACC_WIDTH +: ACC_WIDTH];
            w_sum[i*ACC_WIDTH +: ACC_WIDTH] =
                w_acc + f_dot(i_tensor, w_tensor[i*ROW_WIDTH +: ROW_WIDTH]);
        end
    end

    // The result register only loads on a valid op, so idle or undriven
    // operands never disturb the held output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out <= '0;
            r_vld <= 1'b0;
        end else begin
            r_vld <= in_valid;
            if (in_valid) begin
                r_out <= w_sum;
            end
        end
    end

    assign o_tensor  = r_out;
    assign out_valid = r_vld;

endmodule

// File: tb/tb_gemm_op.sv
module tb_gemm_op;

    localparam int N  = 16;
    localparam int IW = 8 * N;
    localparam int WW = 8 * N * N;
    localparam int AW = 32 * N;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          acc_clear;
    logic [IW-1:0] i_t;
    logic [WW-1:0] w_t;
    logic [AW-1:0] a_t;
    logic [AW-1:0] o_tensor;
    logic          out_valid;

    int n_chk  = 0;
    int n_fail = 0;

    logic [AW-1:0] exp_out;
    logic          exp_vld;
    logic          model_init = 1'b0;
    logic [AW-1:0] held;

    gemm_op dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .acc_clear (acc_clear),
        .i_tensor  (i_t),
        .w_tensor  (w_t),
        .a_tensor  (a_t),
        .o_tensor  (o_tensor),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: straight nested loops over integers, 32-bit int wraps naturally.
    function automatic logic [AW-1:0] ref_gemm(input logic [IW-1:0] x, input logic [WW-1:0] w,
                                               input logic [AW-1:0] a, input logic clr);
        logic [AW-1:0] r;
        logic [7:0]    xb;
        logic [7:0]    wb;
        int            s;
        r = '0;
        for (int i = 0; i < N; i++) begin
            s = clr ? 0 : int'(a[i*32 +: 32]);
            for (int j = 0; j < N; j++) begin
                xb = x[j*8 +: 8];
                wb = w[(i*N+j)*8 +: 8];
                s  = s + int'($signed(xb)) * int'($signed(wb));
            end
            r[i*32 +: 32] = s;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            exp_vld    = 1'b0;
            exp_out    = '0;
            model_init = 1'b1;
        end else if (model_init) begin
            exp_vld = in_valid;
            if (in_valid) exp_out = ref_gemm(i_t, w_t, a_t, acc_clear);
        end
    end

    always @(negedge clk) begin
        if (model_init) begin
            n_chk++;
            if (out_valid !== exp_vld) begin
                n_fail++;
                $display("FAIL model_valid t=%0t got=%b want=%b", $time, out_valid, exp_vld);
            end
            n_chk++;
            if (o_tensor !== exp_out) begin
                n_fail++;
                $display("FAIL model_tensor t=%0t got=%h want=%h", $time, o_tensor, exp_out);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end
    endtask

    function automatic logic [31:0] lane(input int k);
        return o_tensor[k*32 +: 32];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        for (int k = 0; k < IW / 32; k++) i_t[k*32 +: 32] = $urandom();
        for (int k = 0; k < WW / 32; k++) w_t[k*32 +: 32] = $urandom();
        for (int k = 0; k < AW / 32; k++) a_t[k*32 +: 32] = $urandom();
    endtask

    task automatic fill(input logic [7:0] xv, input logic [7:0] wv);
        for (int j = 0; j < N; j++) i_t[j*8 +: 8] = xv;
        for (int k = 0; k < N * N; k++) w_t[k*8 +: 8] = wv;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        acc_clear = 1'b0;
        rand_ops();
        // Reset dominates a simultaneous valid op.
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("reset_valid", {31'd0, out_valid}, 32'd0);
            chk("reset_lane0", lane(0), 32'd0);
            chk("reset_lane15", lane(15), 32'd0);
            rand_ops();
        end

        // Identity as first op after release.
        rst_n = 1'b1;
        i_t = '0; w_t = '0; a_t = '0;
        for (int j = 0; j < N; j++) begin
            i_t[j*8 +: 8]         = 8'(j - 8);
            w_t[(j*N+j)*8 +: 8]   = 8'd1;
        end
        tick();
        chk("ident_valid", {31'd0, out_valid}, 32'd1);
        chk("ident_lane0", lane(0), 32'hFFFF_FFF8);
        chk("ident_lane7", lane(7), 32'hFFFF_FFFF);
        chk("ident_lane8", lane(8), 32'd0);
        chk("ident_lane15", lane(15), 32'd7);

        fill(8'h80, 8'h80); a_t = '0;
        tick();
        chk("ext_neg_neg_lane3", lane(3), 32'd262144);
        fill(8'h80, 8'h7F);
        tick();
        chk("ext_neg_pos_lane12", lane(12), 32'hFFFC_0800);

        fill(8'd1, 8'd1);
        for (int i = 0; i < N; i++) a_t[i*32 +: 32] = 32'(i * 1000);
        tick();
        chk("accum_lane0", lane(0), 32'd16);
        chk("accum_lane5", lane(5), 32'd5016);
        chk("accum_lane15", lane(15), 32'd15016);
        acc_clear = 1'b1;
        tick();
        chk("clear_lane5", lane(5), 32'd16);
        chk("clear_lane15", lane(15), 32'd16);
        acc_clear = 1'b0;

        i_t = '0; w_t = '0;
        i_t[7:0] = 8'd1;
        for (int i = 0; i < N; i++) begin
            w_t[(i*N)*8 +: 8] = 8'd1;
            a_t[i*32 +: 32]   = 32'h7FFF_FFFF;
        end
        tick();
        chk("wrap_lane0", lane(0), 32'h8000_0000);
        chk("wrap_lane9", lane(9), 32'h8000_0000);

        // Back-to-back random ops; the per-cycle model compare covers each result.
        for (int c = 0; c < 5; c++) begin
            rand_ops();
            acc_clear = 1'(c == 2);
            tick();
            chk("stream_valid", {31'd0, out_valid}, 32'd1);
        end
        held      = o_tensor;
        in_valid  = 1'b0;
        acc_clear = 1'b1;
        rand_ops();
        tick();
        chk("gap_valid", {31'd0, out_valid}, 32'd0);
        n_chk++;
        if (o_tensor !== held) begin
            n_fail++;
            $display("FAIL gap_hold got=%h want=%h", o_tensor, held);
        end

        // Idle cycles with junk operands, then a valid op killed by reset.
        for (int c = 0; c < 3; c++) begin
            rand_ops();
            acc_clear = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid = 1'b1; acc_clear = 1'b0;
        rand_ops();
        tick();
        chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        rand_ops();
        tick();
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_lane4", lane(4), 32'd0);
        rst_n = 1'b1;
        fill(8'd2, 8'hFF); a_t = '0;
        tick();
        chk("post_flush_lane1", lane(1), 32'hFFFF_FFE0);
        in_valid = 1'b0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gemm_op.md
Name: gemm_op

Overview:
- Registered GEMM tile core.
- Computes a 16-element signed output vector: out = acc + W·inp, where W is a 16x16 int8 weight block, inp is a 16-lane int8 input vector and acc is a 16-lane int32 accumulator.
- Sits between the input/weight/accumulator buffers and the accumulator write-back.
- One result vector per cycle, fixed single-cycle latency, valid-qualified.

Parameters:
- INP_WIDTH, 8, bits per signed input element.
- WGT_WIDTH, 8, bits per signed weight element.
- ACC_WIDTH, 32, bits per signed accumulator/output element.
- INP_DEPTH, 16, vector length N; weight block is N x N.
- WGT_DEPTH, INP_DEPTH*INP_DEPTH, number of weight elements.
- IT_WIDTH, INP_WIDTH*INP_DEPTH, packed input bus width (128).
- WT_WIDTH, WGT_WIDTH*WGT_DEPTH, packed weight bus width (2048).
- AT_WIDTH, ACC_WIDTH*INP_DEPTH, packed accumulator/output bus width (512).

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, synchronous active-low reset.
- in_valid, input, 1, operands valid this cycle.
- acc_clear, input, 1, treat a_tensor as zero for this operation.
- i_tensor, input, IT_WIDTH, input lane j at [j*INP_WIDTH +: INP_WIDTH].
- w_tensor, input, WT_WIDTH, weight W[i][j] at [(i*INP_DEPTH+j)*WGT_WIDTH +: WGT_WIDTH]; i = output lane, j = input lane.
- a_tensor, input, AT_WIDTH, accumulator lane i at [i*ACC_WIDTH +: ACC_WIDTH].
- o_tensor, output, AT_WIDTH, result lane i at [i*ACC_WIDTH +: ACC_WIDTH].
- out_valid, output, 1, o_tensor holds a new result.

Behaviour:
- All elements are two's-complement signed.
- Per lane: o[i] = (acc_clear ? 0 : a[i]) + sum over j=0..N-1 of (i[j] * W[i][j]).
- Products are 16-bit signed, sign-extended to ACC_WIDTH before summation.
- Summation is modulo 2^ACC_WIDTH: wrap-around, no saturation, no overflow flag.
- Sum structure is a balanced adder tree (implementer's choice of grouping); the result must be bit-exact to sequential modular addition.
- Datapath is combinational from inputs to one output register stage; no other state.
- Latency: operands sampled at rising edge k when in_valid=1; o_tensor and out_valid=1 visible after edge k, held during cycle k+1.
- in_valid=0 at an edge: out_valid goes 0 on that edge, o_tensor holds its last value.
- Throughput: one operation per cycle; no backpressure or ready signal; the consumer must accept out_valid every cycle.
- acc_clear is only meaningful with in_valid=1; ignored otherwise.
- Reset: rst_n=0 at a rising edge clears o_tensor to all zeros and out_valid to 0. Reset takes priority over a simultaneous in_valid.
- An operation in flight when reset is asserted is discarded and no result emerges.
- The first valid operation after rst_n rises behaves normally.
- X/undriven operands with in_valid=0 must not affect outputs.
- Must synthesize for generic parameters; N=16 is the production configuration.

Test Plan:
- Reset: rst_n=0 for 2 cycles with random operands and in_valid=1 → o_tensor=0, out_valid=0. First valid op after release yields its correct result one cycle later.
- Identity: W=I (W[i][i]=1, else 0), inp lane j = j-8, a=0, in_valid=1 → next cycle o[j]=j-8 for all lanes, sign-extended (o[0]=32'hFFFFFFF8), out_valid=1.
- Extremes: all inp=-128, all W=-128, a=0 → each o[i]=16*16384=262144. All inp=-128, all W=127 → each o[i]=-260096.
- Accumulate and clear:
  - All inp=1, all W=1, a[i]=i*1000 → o[i]=16+i*1000.
  - Same with acc_clear=1 → o[i]=16.
- Wrap: a[i]=32'h7FFFFFFF, inp[0]=1, W[i][0]=1, others 0 → o[i]=32'h80000000, no saturation.
- Streaming: back-to-back in_valid for 5 cycles with distinct random operands, then a 1-cycle in_valid gap → each result matches the reference model one cycle after its input. During the gap out_valid=0 and o_tensor holds its last value.
